// File: rtl/integ_dump_tdm.sv
// Time-multiplexed integrate-and-dump: one accumulator and one sample counter per channel.
// Optional saturating arithmetic with a sticky per-channel clip flag: define INTEG_SAT_EN.
module integ_dump_tdm #(
  parameter int WIN  = 16,
  parameter int WG   = 22,
  parameter int NCH  = 4,
  parameter int CNTW = 16,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int WACC = WIN + WG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            val_in,
  input  logic [CHW-1:0]  ch_in,
  input  logic [WIN-1:0]  data_in,
  input  logic [CNTW-1:0] dump_len,
  input  logic            clr,
  output logic            val_out,
  output logic [CHW-1:0]  ch_out,
  output logic [WACC-1:0] data_out,
  output logic            sat_out
);

  logic [WACC-1:0] acc [NCH];
  logic [CNTW-1:0] cnt [NCH];

  logic            ch_ok;
  logic            take;
  logic [WACC-1:0] acc_sel;
  logic [CNTW-1:0] cnt_sel;
  logic [CNTW-1:0] len_m1;
  logic            dump;
  logic [WACC-1:0] data_ext;
  logic [WACC-1:0] sum;

  // Out-of-range channel indices only exist when NCH is not a power of two.
  generate
    if (NCH == (1 << CHW)) begin : g_full
      assign ch_ok = 1'b1;
    end else begin : g_part
      assign ch_ok = (32'(ch_in) < 32'(NCH));
    end
  endgenerate

  assign take     = val_in & ~clr & ch_ok;
  assign data_ext = {{WG{data_in[WIN-1]}}, data_in};
  assign len_m1   = (dump_len == '0) ? '0 : dump_len - CNTW'(1);
  assign dump     = (cnt_sel >= len_m1);

  // Select the addressed channel's state for the shared adder.
  always_comb begin
    acc_sel = '0;
    cnt_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_in == CHW'(c)) begin
        acc_sel = acc[c];
        cnt_sel = cnt[c];
      end
    end
  end

`ifdef INTEG_SAT_EN
  logic            sat_f [NCH];
  logic            sat_sel;
  logic [WACC:0]   wide;
  logic            clip;
  logic            sat_r;

  // Pick the sticky flag of the addressed channel.
  always_comb begin
    sat_sel = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_in == CHW'(c)) sat_sel = sat_f[c];
    end
  end

  // Add one bit wider, then clip back onto the signed rails.
  always_comb begin
    wide = {acc_sel[WACC-1], acc_sel} + {data_ext[WACC-1], data_ext};
    clip = wide[WACC] ^ wide[WACC-1];
    sum  = wide[WACC-1:0];
    if (clip) begin
      sum = wide[WACC] ? {1'b1, {(WACC-1){1'b0}}}
                       : {1'b0, {(WACC-1){1'b1}}};
    end
  end

  // Sticky clip flags; a dump reports and restarts the channel's flag.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int c = 0; c < NCH; c++) sat_f[c] <= 1'b0;
    end else if (take) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_in == CHW'(c)) sat_f[c] <= dump ? 1'b0 : (sat_sel | clip);
      end
    end
  end

  // Registered clip report, held between dumps.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_r <= 1'b0;
    end else if (take && dump) begin
      sat_r <= sat_sel | clip;
    end
  end

  assign sat_out = sat_r;
`else
  // Plain modulo-2^WACC accumulation.
  always_comb begin
    sum = acc_sel + data_ext;
  end

  assign sat_out = 1'b0;
`endif

  // Per-channel accumulators and counters; clr and rst drop every partial sum.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int c = 0; c < NCH; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
    end else if (take) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_in == CHW'(c)) begin
          if (dump) begin
            acc[c] <= '0;
            cnt[c] <= '0;
          end else begin
            acc[c] <= sum;
            cnt[c] <= cnt[c] + CNTW'(1);
          end
        end
      end
    end
  end

  // Dump result register: one-cycle valid pulse, payload held until next dump.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_out  <= 1'b0;
      ch_out   <= '0;
      data_out <= '0;
    end else begin
      val_out <= take & dump;
      if (take && dump) begin
        ch_out   <= ch_in;
        data_out <= sum;
      end
    end
  end

endmodule

// File: tb/tb_integ_dump_tdm.sv
// Bench for integ_dump_tdm: directed steps, expected dumps queued at drive time.
// NCH=5 so an out-of-range channel index is representable; WG=2 to reach the wrap/clip rail.
module tb_integ_dump_tdm;

  localparam int WIN  = 16;
  localparam int WG   = 2;
  localparam int NCH  = 5;
  localparam int CNTW = 16;
  localparam int CHW  = 3;
  localparam int WACC = WIN + WG;

`ifdef INTEG_SAT_EN
  localparam longint T6_DATA = 131071;
  localparam logic   T6_SAT  = 1'b1;
`else
  localparam longint T6_DATA = -8;
  localparam logic   T6_SAT  = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            val_in = 1'b0;
  logic [CHW-1:0]  ch_in = '0;
  logic [WIN-1:0]  data_in = '0;
  logic [CNTW-1:0] dump_len = '0;
  logic            clr = 1'b0;
  logic            val_out;
  logic [CHW-1:0]  ch_out;
  logic [WACC-1:0] data_out;
  logic            sat_out;

  integ_dump_tdm #(
    .WIN(WIN), .WG(WG), .NCH(NCH), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .val_in(val_in), .ch_in(ch_in),
    .data_in(data_in), .dump_len(dump_len), .clr(clr),
    .val_out(val_out), .ch_out(ch_out), .data_out(data_out),
    .sat_out(sat_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CHW-1:0]     ch;
    logic signed [63:0] data;
    logic               sat;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] sdo();
    return 64'($signed(data_out));
  endfunction

  // Scoreboard: every valid pulse must match the oldest queued dump.
  always @(negedge clk) begin
    if (val_out === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious val_out", 64'(val_out), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ch_out", 64'(ch_out), 64'(e.ch));
        chk("data_out", sdo(), e.data);
        chk("sat_out", 64'(sat_out), 64'(e.sat));
      end
    end
  end

  task automatic send(input int ch, input int d);
    @(negedge clk);
    val_in  = 1'b1;
    clr     = 1'b0;
    ch_in   = ch[CHW-1:0];
    data_in = d[WIN-1:0];
  endtask

  task automatic send_d(input int ch, input int d,
                        input longint exp, input logic sat);
    exp_t e;
    send(ch, d);
    e.ch   = ch[CHW-1:0];
    e.data = 64'(exp);
    e.sat  = sat;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      val_in = 1'b0;
      clr    = 1'b0;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " val_out"}, 64'(val_out), 64'd0);
    chk({tag, " ch_out"}, 64'(ch_out), 64'd0);
    chk({tag, " data_out"}, sdo(), 64'sd0);
    chk({tag, " sat_out"}, 64'(sat_out), 64'd0);
  endtask

  initial begin
    dump_len = 16'd4;
    rst = 1'b1;
    idle(2);
    chk_reset_state("reset");
    rst = 1'b0;

    // L=4 on ch0: 1+2+3+4, then a fresh period of ones.
    send(0, 1);
    send(0, 2);
    send(0, 3);
    send_d(0, 4, 10, 1'b0);
    idle(2);
    chk("t1 pulse width", 64'(val_out), 64'd0);
    chk("t1 hold data", sdo(), 64'sd10);
    send(0, 1);
    send(0, 1);
    send(0, 1);
    send_d(0, 1, 4, 1'b0);
    idle(1);

    // L=2 round robin, no cross-talk.
    dump_len = 16'd2;
    send(0, 100);
    send(1, -100);
    send(2, 7);
    send(3, 0);
    send_d(0, 100, 200, 1'b0);
    send_d(1, -100, -200, 1'b0);
    send_d(2, 7, 14, 1'b0);
    send_d(3, 0, 0, 1'b0);
    idle(1);

    // dump_len=0 behaves as L=1, back-to-back dumps.
    dump_len = 16'd0;
    send_d(2, 5, 5, 1'b0);
    send_d(2, -3, -3, 1'b0);
    idle(2);

    // clr beats a simultaneous sample; outputs hold.
    dump_len = 16'd8;
    send(1, 1);
    send(1, 1);
    send(1, 1);
    @(negedge clk);
    val_in  = 1'b1;
    clr     = 1'b1;
    ch_in   = 3'd1;
    data_in = 16'd1;
    idle(1);
    chk("t4 clr val_out", 64'(val_out), 64'd0);
    chk("t4 clr hold data", sdo(), -64'sd3);
    chk("t4 clr hold ch", 64'(ch_out), 64'd2);
    repeat (7) send(1, 1);
    send_d(1, 1, 8, 1'b0);
    idle(1);

    // Shrinking dump_len mid-period dumps on the next sample.
    send(3, 1);
    send(3, 1);
    send(3, 1);
    idle(1);
    dump_len = 16'd2;
    send_d(3, 1, 4, 1'b0);
    idle(1);

    // Overflow past the accumulator range.
    dump_len = 16'd8;
    repeat (7) send(0, 32767);
    send_d(0, 32767, T6_DATA, T6_SAT);
    idle(1);
    dump_len = 16'd2;
    send(0, 1);
    send_d(0, 1, 2, 1'b0);
    idle(1);

    // Ignored channel and reset mid-period.
    dump_len = 16'd3;
    send(0, 1);
    send(0, 1);
    send(5, 50);
    @(negedge clk);
    val_in = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("mid rst");
    send(0, 2);
    send(0, 2);
    send(7, 100);
    send_d(0, 2, 6, 1'b0);
    idle(3);

    chk("queue drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
